// File: rtl/axi_rd_rr_arb_pkg.sv
// Shared definitions for the AXI read-channel round-robin arbiter.
// Contents: FSM state encoding, AXI burst/response constants, and an index-width helper
// that sizes grant registers for a given master count.
package axi_rd_rr_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAr   = 2'd1,
        StR    = 2'd2
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/axi_rd_rr_arb_if.sv
// Signal bundle around the read arbiter: upstream per-master AR/R (m_*) and the single
// downstream AR/R channel (s_*). Per-master vectors hold master i in slice i.
// Modports:
//   slave  - the arbiter's view (consumes master requests and slave responses)
//   master - the environment's view (drives requests and responses)
interface axi_rd_rr_arb_if #(
    parameter int unsigned NUM_M      = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [NUM_M*ADDR_WIDTH-1:0] m_araddr;
    logic [NUM_M*8-1:0]          m_arlen;
    logic [NUM_M*3-1:0]          m_arsize;
    logic [NUM_M*2-1:0]          m_arburst;
    logic [NUM_M-1:0]            m_arvalid;
    logic [NUM_M-1:0]            m_arready;
    logic [DATA_WIDTH-1:0]       m_rdata;
    logic [1:0]                  m_rresp;
    logic                        m_rlast;
    logic [NUM_M-1:0]            m_rvalid;
    logic [NUM_M-1:0]            m_rready;

    logic [ID_WIDTH-1:0]         s_arid;
    logic [ADDR_WIDTH-1:0]       s_araddr;
    logic [7:0]                  s_arlen;
    logic [2:0]                  s_arsize;
    logic [1:0]                  s_arburst;
    logic                        s_arvalid;
    logic                        s_arready;
    logic [ID_WIDTH-1:0]         s_rid;
    logic [DATA_WIDTH-1:0]       s_rdata;
    logic [1:0]                  s_rresp;
    logic                        s_rlast;
    logic                        s_rvalid;
    logic                        s_rready;

    modport slave (
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready
    );

    modport master (
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready
    );

endinterface

// File: rtl/axi_rd_rr_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   last_i  - index of the previously granted requester
//   idx_o   - first requester found searching upward from last_i+1 with wrap
//   valid_o - at least one request is present
module axi_rd_rr_arb_rr_pick #(
    parameter int unsigned NumM = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [NumM-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NumM; k++) begin
            cand = IdxW'((32'(last_i) + k) % NumM);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/axi_rd_rr_arb.sv
// Round-robin arbiter sharing one AXI4 read channel among NUM_M masters, one burst at a
// time. The granted master's index is issued as ARID; R beats are steered back to it and
// checked against the granted ARLEN and ID, raising a sticky proto_err on mismatch.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   bus       - upstream per-master AR/R and downstream AR/R (slave modport)
//   proto_err - sticky protocol-error flag, cleared only by rst
module axi_rd_rr_arb
    import axi_rd_rr_arb_pkg::*;
#(
    parameter int unsigned NUM_M      = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    axi_rd_rr_arb_if.slave  bus,
    output logic            proto_err
);

    localparam int unsigned GW = idx_width(NUM_M);

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [7:0]      arlen_q, arlen_d;
    logic [7:0]      beat_q, beat_d;
    logic            proto_err_q, proto_err_d;

    logic [GW-1:0]   pick_idx;
    logic            pick_valid;
    logic            ar_hs, r_hs, len_bad, id_bad;

    axi_rd_rr_arb_rr_pick #(
        .NumM (NUM_M),
        .IdxW (GW)
    ) u_pick (
        .req_i   (bus.m_arvalid),
        .last_i  (last_grant_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign ar_hs   = (state_q == StAr) && bus.m_arvalid[grant_q] && bus.s_arready;
    assign r_hs    = (state_q == StR) && bus.s_rvalid && bus.m_rready[grant_q];
    // Last must coincide exactly with the beat numbered arlen.
    assign len_bad = bus.s_rlast != (beat_q == arlen_q);
    assign id_bad  = bus.s_rid != ID_WIDTH'(grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        arlen_d      = arlen_q;
        beat_d       = beat_q;
        proto_err_d  = proto_err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    arlen_d = bus.m_arlen[int'(pick_idx)*8 +: 8];
                    state_d = StAr;
                end
            end
            StAr: begin
                if (ar_hs) begin
                    beat_d  = '0;
                    state_d = StR;
                end
            end
            StR: begin
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (len_bad || id_bad) begin
                        proto_err_d = 1'b1;
                    end
                    if (bus.s_rlast) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.s_arid    = ID_WIDTH'(grant_q);
        bus.s_araddr  = bus.m_araddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_arlen   = bus.m_arlen[int'(grant_q)*8 +: 8];
        bus.s_arsize  = bus.m_arsize[int'(grant_q)*3 +: 3];
        bus.s_arburst = bus.m_arburst[int'(grant_q)*2 +: 2];
        bus.s_arvalid = 1'b0;
        bus.s_rready  = 1'b0;
        bus.m_arready = '0;
        bus.m_rvalid  = '0;
        bus.m_rdata   = DATA_WIDTH'(bus.s_rdata);
        bus.m_rresp   = bus.s_rresp;
        bus.m_rlast   = bus.s_rlast;
        if (state_q == StAr) begin
            bus.s_arvalid          = bus.m_arvalid[grant_q];
            bus.m_arready[grant_q] = bus.s_arready;
        end
        if (state_q == StR) begin
            bus.m_rvalid[grant_q] = bus.s_rvalid;
            bus.s_rready          = bus.m_rready[grant_q];
        end
    end

    assign proto_err = proto_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_M - 1);
            arlen_q      <= '0;
            beat_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            arlen_q      <= arlen_d;
            beat_q       <= beat_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_rr_arb.sv
// Self-checking bench for axi_rd_rr_arb: directed scenarios followed by randomized bursts,
// checked against a round-robin/burst-length model kept in the bench.
module tb_axi_rd_rr_arb;
    import axi_rd_rr_arb_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    always #5 clk = ~clk;

    axi_rd_rr_arb_if #(.NUM_M(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi_rd_rr_arb #(
        .NUM_M      (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .proto_err (proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Model state: previously served master and expected sticky error.
    int         last_g;
    bit         err_m;
    logic [7:0]  len_of  [N];
    logic [31:0] addr_of [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_ar();
        for (int i = 0; i < N; i++) begin
            bus.m_araddr[i*AW +: AW] = addr_of[i];
            bus.m_arlen[i*8 +: 8]    = len_of[i];
            bus.m_arsize[i*3 +: 3]   = 3'd2;
            bus.m_arburst[i*2 +: 2]  = BURST_INCR;
        end
    endtask

    // Next master in round-robin order after last_g among those requesting.
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            int c = (last_g + k) % N;
            if (mask[c]) return c;
        end
        return 0;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_arvalid"}, bus.s_arvalid, 0);
        chk({tag, "_m_arready"}, bus.m_arready, 0);
        chk({tag, "_m_rvalid"}, bus.m_rvalid, 0);
        chk({tag, "_s_rready"}, bus.s_rready, 0);
        chk({tag, "_proto_err"}, proto_err, 0);
    endtask

    // Runs one arbitration + burst, entered and left at a negedge with the DUT idle.
    // kind: 0 clean, 1 rlast early at beat kpos, 2 wrong rid, 3 rlast one beat late.
    // rst_at >= 0 asserts reset while that beat is presented and abandons the burst.
    task automatic burst(input logic [N-1:0] mask, input bit hold, input int kind,
                         input int kpos, input int stall_at, input int stall_n,
                         input int rst_at);
        int g;
        int lastb;
        logic [DW-1:0] d;
        logic [IW-1:0] rid;
        logic [N-1:0] onehot;
        bus.m_arvalid = mask;
        load_ar();
        #1;
        chk("idle_s_arvalid", bus.s_arvalid, 0);
        chk("idle_m_arready", bus.m_arready, 0);
        g = model_pick(mask);
        onehot = '0;
        onehot[g] = 1'b1;
        @(negedge clk);
        #1;
        chk("ar_s_arvalid", bus.s_arvalid, 1);
        chk("ar_s_arid", bus.s_arid, g);
        chk("ar_s_araddr", bus.s_araddr, addr_of[g]);
        chk("ar_s_arlen", bus.s_arlen, len_of[g]);
        bus.s_arready = 1'b1;
        #1;
        chk("ar_m_arready", bus.m_arready, onehot);
        @(negedge clk);
        bus.s_arready = 1'b0;
        if (!hold) bus.m_arvalid[g] = 1'b0;
        lastb = (kind == 1) ? kpos : (kind == 3) ? int'(len_of[g]) + 1 : int'(len_of[g]);
        rid = (kind == 2) ? IW'((g + 1) % N) : IW'(g);
        for (int b = 0; b <= lastb; b++) begin
            if (b == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    bus.m_rready = ~onehot;
                    bus.s_rvalid = 1'b1;
                    bus.s_rlast  = 1'b0;
                    #1;
                    chk("stall_s_rready", bus.s_rready, 0);
                    chk("stall_m_rvalid", bus.m_rvalid, onehot);
                    @(negedge clk);
                end
            end
            d = $urandom;
            bus.m_rready = '1;
            bus.s_rvalid = 1'b1;
            bus.s_rdata  = d;
            bus.s_rid    = rid;
            bus.s_rresp  = RESP_OKAY;
            bus.s_rlast  = (b == lastb);
            if (b == rst_at) begin
                rst = 1'b1;
                #1;
                chk_reset_outputs("midrst");
                last_g = N - 1;
                err_m  = 1'b0;
                bus.s_rvalid  = 1'b0;
                bus.s_rlast   = 1'b0;
                bus.m_arvalid = '0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            chk("r_m_rvalid", bus.m_rvalid, onehot);
            chk("r_s_rready", bus.s_rready, 1);
            chk("r_m_rdata", bus.m_rdata, d);
            chk("r_m_rlast", bus.m_rlast, (b == lastb));
            chk("r_m_rresp", bus.m_rresp, RESP_OKAY);
            @(negedge clk);
        end
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
        if (lastb != int'(len_of[g]) || kind == 2) err_m = 1'b1;
        last_g = g;
        #1;
        chk("end_proto_err", proto_err, err_m);
        chk("end_m_rvalid", bus.m_rvalid, 0);
        chk("end_s_rready", bus.s_rready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] mask;
        int r;
        int kind;
        int kpos;
        rst = 1'b1;
        bus.m_arvalid = '0;
        bus.m_rready  = '0;
        bus.s_arready = 1'b0;
        bus.s_rid     = '0;
        bus.s_rdata   = '0;
        bus.s_rresp   = RESP_OKAY;
        bus.s_rlast   = 1'b0;
        bus.s_rvalid  = 1'b0;
        for (int i = 0; i < N; i++) begin
            addr_of[i] = $urandom;
            len_of[i]  = 8'd0;
        end
        load_ar();
        last_g = N - 1;
        err_m  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // All masters request out of reset with arlen=0, held: order 0,1,2,0,1.
        for (int i = 0; i < 5; i++) burst(3'b111, 1'b1, 0, 0, -1, 0, -1);
        bus.m_arvalid = '0;

        // Master 1 alone, four beats.
        addr_of[1] = 32'h100;
        len_of[1]  = 8'd3;
        burst(3'b010, 1'b0, 0, 0, -1, 0, -1);

        // Master 2, eight beats with a 5-cycle rready stall mid-burst.
        len_of[2] = 8'd7;
        burst(3'b100, 1'b0, 0, 0, 4, 5, -1);

        // Randomized clean bursts with random stalls.
        for (int i = 0; i < 20; i++) begin
            for (int m = 0; m < N; m++) begin
                len_of[m]  = 8'($urandom_range(0, 5));
                addr_of[m] = $urandom;
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            burst(mask, 1'b0, 0, 0, $urandom_range(0, 6), $urandom_range(0, 3), -1);
        end
        bus.m_arvalid = '0;

        // Early rlast, then a master-2 burst answered with the wrong rid.
        len_of[0] = 8'd3;
        burst(3'b001, 1'b0, 1, 2, -1, 0, -1);
        len_of[2] = 8'd1;
        burst(3'b100, 1'b0, 2, 0, -1, 0, -1);

        // Reset during beat 3 of an eight-beat burst, then all request: master 0 first.
        len_of[1] = 8'd7;
        burst(3'b010, 1'b0, 0, 0, -1, 0, 3);
        for (int m = 0; m < N; m++) len_of[m] = 8'd1;
        burst(3'b111, 1'b0, 0, 0, -1, 0, -1);

        // Randomized bursts including length and ID faults.
        for (int i = 0; i < 12; i++) begin
            for (int m = 0; m < N; m++) len_of[m] = 8'($urandom_range(0, 4));
            mask = N'($urandom_range(1, (1 << N) - 1));
            r = $urandom_range(0, 9);
            kind = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
            kpos = 0;
            // Early last needs a beat before the last one; the granted master's len decides.
            if (kind == 1 && len_of[model_pick(mask)] == 8'd0) kind = 0;
            if (kind == 1) kpos = $urandom_range(0, int'(len_of[model_pick(mask)]) - 1);
            burst(mask, 1'b0, kind, kpos, $urandom_range(0, 5), $urandom_range(0, 2), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_rr_arb.md
Name: axi_rd_rr_arb

Overview:
Round-robin arbiter that shares one AXI4 read channel (AR/R) between NUM_M read masters, e.g. icache, dcache read path and a future DMA/prefetch engine. It sits between the cache/IF wrappers and the downstream AXI RAM or interconnect. Only one burst is outstanding at a time. It also checks R-burst length against the granted ARLEN and raises a sticky protocol-error flag on mismatch.

Parameters:
NUM_M, 3, number of read masters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
ID_WIDTH, 4, AXI ID width; must satisfy 2^ID_WIDTH >= NUM_M

Ports:
clk  in  1  sole clock
rst  in  1  asynchronous reset, active-high
m_araddr  in  NUM_M*ADDR_WIDTH  per-master AR address, master i in slice i
m_arlen  in  NUM_M*8  per-master burst length-1
m_arsize  in  NUM_M*3  per-master beat size
m_arburst  in  NUM_M*2  per-master burst type
m_arvalid  in  NUM_M  per-master AR valid
m_arready  out  NUM_M  per-master AR ready
m_rdata  out  DATA_WIDTH  R data, broadcast to all masters
m_rresp  out  2  R response, broadcast
m_rlast  out  1  R last, broadcast
m_rvalid  out  NUM_M  R valid, one-hot to granted master
m_rready  in  NUM_M  per-master R ready
s_arid  out  ID_WIDTH  granted master index, zero-extended
s_araddr / s_arlen / s_arsize / s_arburst  out  ADDR_WIDTH/8/3/2  muxed from granted master
s_arvalid  out  1  downstream AR valid
s_arready  in  1  downstream AR ready
s_rid  in  ID_WIDTH  downstream R ID
s_rdata  in  DATA_WIDTH  downstream R data
s_rresp  in  2  downstream R response
s_rlast  in  1  downstream R last
s_rvalid  in  1  downstream R valid
s_rready  out  1  downstream R ready
proto_err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Registered state: state {IDLE, AR, R}, grant (clog2 NUM_M bits), last_grant, latched arlen, beat counter (8 bits), proto_err.
- Reset (async, rst=1): state=IDLE, grant=0, last_grant=NUM_M-1 so master 0 has first priority, beat=0, proto_err=0. A reset mid-burst abandons the burst immediately, with no draining.
- Reset values of outputs: s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0, proto_err=0. s_ar* payload is don't-care but is driven from grant=0.
- IDLE:
  - All m_arready=0, s_arvalid=0, s_rready=0.
  - If any m_arvalid is set, grant <= first requester searching from last_grant+1 modulo NUM_M, upward with wrap. Latch that master's arlen and go to AR.
  - Arbitration costs exactly one cycle. The earliest s_arvalid is one cycle after the m_arvalid request is seen.
- AR:
  - s_arvalid = m_arvalid[grant]. s_ar* are combinationally muxed from master grant. m_arready[grant] = s_arready; all other m_arready=0.
  - Masters must hold AR stable per AXI; arbiter behaviour is undefined if a granted master withdraws arvalid.
  - On s_arvalid & s_arready: beat<=0, go to R.
- R:
  - m_rvalid[grant] = s_rvalid; all other m_rvalid=0. s_rready = m_rready[grant]. rdata/rresp/rlast pass through combinationally, with zero-latency forwarding.
  - On each beat handshake, beat<=beat+1 (8-bit, no wrap is reachable when arlen≤255).
  - Set proto_err if any of these occurs on a handshaked beat:
    - s_rlast=1 while beat != latched arlen (early last);
    - s_rlast=0 while beat == latched arlen (missing last);
    - s_rid != grant.
  - Data is still forwarded on error.
  - On a handshaked beat with s_rlast=1: last_grant<=grant, go to IDLE.
  - A missing last keeps the arbiter in R until s_rlast arrives.
- Other channels: no AR is issued while in R, and there is no interleaving. Sustained throughput is one beat per cycle within a burst, plus 2 cycles of overhead (IDLE + AR minimum) per burst.
- Fairness: a master that keeps requesting is served at most once per NUM_M grants while other masters are requesting.

Decomposition:
- Shared package: state encoding (IDLE/AR/R), AXI burst/resp constants (INCR=2'b01, OKAY=2'b00), and a clog2 helper for grant width.
- One sub-module: rr_pick. It is combinational; given req[NUM_M] and last_grant it returns the next grant index and a valid bit. It is reusable by a future write-channel arbiter.

Test Plan:
1. Master 1 alone, araddr=0x100, arlen=3; slave returns 4 beats with rid=1 → s_arid=1, only m_rvalid[1] toggles, back to IDLE after beat 4, proto_err=0.
2. All 3 masters request simultaneously out of reset, each with arlen=0 and held continuously → grant order 0,1,2,0,1; s_arid matches each.
3. Master 2 in burst arlen=7 with m_rready[2] low for 5 cycles mid-burst → s_rready=0 for those cycles, no beats lost, beat count reaches 8.
4. Slave asserts rlast on beat 2 of an arlen=3 burst → proto_err=1 and stays 1, state returns to IDLE; next request still served.
5. Slave returns rid=0 for a master-2 grant → proto_err=1.
6. Assert rst during beat 3 of an arlen=7 burst → outputs go to reset values immediately; after release, a master-0 request is granted first.
